// File: rtl/uart_pkg.sv
// Shared types and width helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick: one-clk pulse every CLKS_PER_TICK clocks.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = cnt_w(CLKS_PER_TICK);
  localparam logic [W-1:0] TERM = W'(CLKS_PER_TICK - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (cnt == TERM) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a first-word-fall-through FIFO.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 27,
  parameter int OVERSAMPLE    = 16,
  parameter int DATA_BITS     = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          done,
  output logic                          frame_err,
  output logic                          overrun
`ifdef UART_RX_PARITY_EN
  ,
  input  logic                          parity_odd,
  output logic                          parity_err
`endif
);

  localparam int OSW = cnt_w(OVERSAMPLE);
  localparam int BCW = cnt_w(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  logic rx_meta, rx_s, rx_prev, fall, tick;
  rx_state_t state, state_n;
  logic [OSW-1:0] os_cnt;
  logic [BCW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic os_clr, bit_clr, bit_shift, stop_sample;
  logic parity_ok, good, full, pop, write;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  uart_tick_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Stage: two-flop synchroniser plus one history flop for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  // Stage: frame FSM; every sample point is a tick at a fixed os_cnt value.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

`ifdef UART_RX_PARITY_EN
  logic par_sample, par_bit;
`endif

  always_comb begin
    state_n     = state;
    os_clr      = 1'b0;
    bit_clr     = 1'b0;
    bit_shift   = 1'b0;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample  = 1'b0;
`endif
    case (state)
      IDLE: if (fall) begin
        os_clr  = 1'b1;
        state_n = START;
      end
      START: if (tick && os_cnt == OS_HALF) begin
        os_clr = 1'b1;
        if (rx_s) begin
          state_n = IDLE;
        end else begin
          bit_clr = 1'b1;
          state_n = DATA;
        end
      end
      DATA: if (tick && os_cnt == OS_LAST) begin
        os_clr    = 1'b1;
        bit_shift = 1'b1;
        if (bit_cnt == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (tick && os_cnt == OS_LAST) begin
          os_clr     = 1'b1;
          par_sample = 1'b1;
          state_n    = STOP;
        end
`else
        state_n = IDLE;
`endif
      end
      STOP: if (tick && os_cnt == OS_LAST) begin
        os_clr      = 1'b1;
        stop_sample = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
    end else begin
      if (os_clr)    os_cnt <= '0;
      else if (tick) os_cnt <= os_cnt + 1'b1;
      if (bit_clr)        bit_cnt <= '0;
      else if (bit_shift) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bit_shift) shift[bit_cnt] <= rx_s;
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (par_sample) par_bit <= rx_s;
  end
  assign parity_ok = (((^shift) ^ par_bit) == parity_odd);
`else
  assign parity_ok = 1'b1;
`endif

  // Stage: FIFO push/pop; a pop frees the slot a full-FIFO push reuses.
  assign good     = stop_sample & rx_s & parity_ok;
  assign full     = (fifo_count == FULL_CNT);
  assign rd_valid = (fifo_count != '0);
  assign pop      = rd_en & rd_valid;
  assign write    = good & (~full | pop);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (write && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !write) fifo_count <= fifo_count - 1'b1;
      done      <= write;
      frame_err <= stop_sample & ~rx_s;
      overrun   <= good & full & ~pop;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= stop_sample & rx_s & ~parity_ok;
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus multi-cycle corner sequences.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CPT = 4, OS = 16, DB = 8, DEPTH = 4;
  localparam int BIT_CLKS = CPT * OS;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1, rd_en = 1'b0;
  logic [DB-1:0] rd_data;
  logic rd_valid, done, frame_err, overrun;
  logic [CW-1:0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic parity_odd = 1'b0, parity_err;
  int n_perr = 0;
`endif
  logic par_flip = 1'b0;

  uart_rx_fifo #(.CLKS_PER_TICK(CPT), .OVERSAMPLE(OS), .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .done(done), .frame_err(frame_err), .overrun(overrun)
`ifdef UART_RX_PARITY_EN
    , .parity_odd(parity_odd), .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_done = 0, n_ferr = 0, n_ovr = 0;
  logic [DB-1:0] exp_q[$];

  always @(negedge clk) begin
    if (done)      n_done++;
    if (frame_err) n_ferr++;
    if (overrun)   n_ovr++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
  end

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    int            exp_done;
    int            exp_ferr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      wait_clks(BIT_CLKS);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ parity_odd ^ par_flip;
    wait_clks(BIT_CLKS);
`endif
    rxd = stop;
    wait_clks(BIT_CLKS);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    wait_clks(n);
  endtask

  task automatic pop_check(input string name);
    int e;
    e = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
    chk({name, "_valid"}, int'(rd_valid), 1);
    chk(name, int'(rd_data), e);
    rd_en = 1'b1;
    wait_clks(1);
    rd_en = 1'b0;
  endtask

  vec_t vecs[6];
  int d0, f0, o0;
  bit found;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1};
    vecs[2] = '{8'h00, 1'b1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 0};
    vecs[4] = '{8'h5A, 1'b0, 0, 1};
    vecs[5] = '{8'h81, 1'b1, 1, 0};

    wait_clks(4);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_flags", int'({done, frame_err, overrun}), 0);
    rst = 1'b0;
    idle(20);

    for (int v = 0; v < 6; v++) begin
      d0 = n_done; f0 = n_ferr;
      send_frame(vecs[v].data, vecs[v].stop);
      idle(100);
      chk($sformatf("vec%0d_done", v), n_done - d0, vecs[v].exp_done);
      chk($sformatf("vec%0d_ferr", v), n_ferr - f0, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_count", v), int'(fifo_count), vecs[v].exp_done);
      if (vecs[v].exp_done != 0) begin
        exp_q.push_back(vecs[v].data);
        pop_check($sformatf("vec%0d_data", v));
      end
      chk($sformatf("vec%0d_empty", v), int'(rd_valid), 0);
    end

    d0 = n_done; f0 = n_ferr;
    rxd = 1'b0;
    wait_clks(20);
    idle(300);
    chk("glitch_done", n_done - d0, 0);
    chk("glitch_ferr", n_ferr - f0, 0);
    chk("glitch_state", int'(dut.state), int'(IDLE));

    d0 = n_done; f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    wait_clks(1000);
    chk("break_ferr", n_ferr - f0, 1);
    chk("break_done", n_done - d0, 0);
    chk("break_count", int'(fifo_count), 0);
    idle(200);
    chk("break_ferr_after", n_ferr - f0, 1);

    d0 = n_done; o0 = n_ovr;
    for (int k = 1; k <= 5; k++) begin
      send_frame(DB'(k), 1'b1);
      idle(20);
      if (k <= 4) exp_q.push_back(DB'(k));
    end
    idle(50);
    chk("ovr_count", int'(fifo_count), 4);
    chk("ovr_pulses", n_ovr - o0, 1);
    chk("ovr_done", n_done - d0, 4);
    for (int k = 0; k < 4; k++) pop_check($sformatf("ovr_pop%0d", k));
    chk("ovr_empty", int'(rd_valid), 0);

    for (int k = 0; k < 4; k++) begin
      send_frame(8'h11 + DB'(k), 1'b1);
      idle(20);
      exp_q.push_back(8'h11 + DB'(k));
    end
    d0 = n_done; o0 = n_ovr; found = 1'b0;
    fork
      send_frame(8'h15, 1'b1);
      begin
        for (int c = 0; c < BIT_CLKS * 12; c++) begin
          @(negedge clk);
          if (dut.stop_sample) begin
            chk("fullpop_head", int'(rd_data), int'(exp_q.pop_front()));
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            found = 1'b1;
            break;
          end
        end
      end
    join
    exp_q.push_back(8'h15);
    idle(50);
    chk("fullpop_found", int'(found), 1);
    chk("fullpop_ovr", n_ovr - o0, 0);
    chk("fullpop_done", n_done - d0, 1);
    chk("fullpop_count", int'(fifo_count), 4);
    for (int k = 0; k < 4; k++) pop_check($sformatf("fullpop_pop%0d", k));

    send_frame(8'h21, 1'b1); idle(20);
    send_frame(8'h22, 1'b1); idle(20);
    chk("pre_rst_count", int'(fifo_count), 2);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rxd = (8'h55 >> i) & 1;
      wait_clks(BIT_CLKS);
    end
    rxd = 1'b0;
    wait_clks(BIT_CLKS / 2);
    d0 = n_done; f0 = n_ferr; o0 = n_ovr;
    rst = 1'b1;
    wait_clks(2);
    chk("midrst_rd_valid", int'(rd_valid), 0);
    chk("midrst_count", int'(fifo_count), 0);
    chk("midrst_rd_data", int'(rd_data), 0);
    chk("midrst_flags", int'({done, frame_err, overrun}), 0);
    rst = 1'b0;
    rxd = 1'b1;
    exp_q.delete();
    idle(600);
    chk("midrst_no_flags", (n_done - d0) + (n_ferr - f0) + (n_ovr - o0), 0);
    send_frame(8'h81, 1'b1);
    idle(100);
    exp_q.push_back(8'h81);
    chk("after_rst_count", int'(fifo_count), 1);
    pop_check("after_rst_data");

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    d0 = n_done;
    f0 = n_perr;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    idle(100);
    chk("par_bad_perr", n_perr - f0, 1);
    chk("par_bad_done", n_done - d0, 0);
    chk("par_bad_count", int'(fifo_count), 0);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    idle(100);
    chk("par_ok_done", n_done - d0, 1);
    chk("par_ok_perr", n_perr - f0, 1);
    exp_q.push_back(8'h07);
    pop_check("par_ok_data");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
